// File: rtl/rx_frame_align_pkg.sv
// Shared SDH framing constants, state encoding and A1/A2 pattern helper
// for the STM-1 receive frame aligner.
package rx_frame_align_pkg;

  localparam int unsigned FRMLEN_DEF  = 2430;
  localparam logic [7:0]  A1PAT_DEF   = 8'hF6;
  localparam logic [7:0]  A2PAT_DEF   = 8'h28;
  localparam int unsigned OOFERR_DEF  = 4;
  localparam int unsigned LOFTIME_DEF = 58320;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WIN_BYTES = 6;
  localparam int unsigned FCNT_W    = 12;
  localparam int unsigned ERRCNT_W  = 3;
  localparam int unsigned LOFTMR_W  = 16;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PRESYNC = 2'd1,
    ST_INFRAME = 2'd2
  } frm_state_e;

  // Framing word as it appears in the byte window, oldest byte in the MSBs.
  function automatic logic [BYTE_W*WIN_BYTES-1:0] frame_pattern(
    input logic [BYTE_W-1:0] a1,
    input logic [BYTE_W-1:0] a2
  );
    return {a1, a1, a1, a2, a2, a2};
  endfunction

endpackage

// File: rtl/rx_frame_align_a1a2_detect.sv
// A1/A2 framing detector: keeps the last five received bytes and flags,
// combinationally, when they plus the current byte form A1,A1,A1,A2,A2,A2.
module rx_frame_align_a1a2_detect
  import rx_frame_align_pkg::*;
#(
  parameter logic [7:0] A1PAT = A1PAT_DEF,
  parameter logic [7:0] A2PAT = A2PAT_DEF
) (
  input  logic              clk19,
  input  logic              rst,
  input  logic [BYTE_W-1:0] dirx,
  output logic              match_c
);

  localparam int unsigned HIST_W = BYTE_W * (WIN_BYTES - 1);

  logic [HIST_W-1:0] hist_q;
  logic [HIST_W-1:0] hist_d;

  always_comb begin
    hist_d  = {hist_q[HIST_W-BYTE_W-1:0], dirx};
    match_c = ({hist_q, dirx} == frame_pattern(A1PAT, A2PAT));
  end

  // Zeroed history cannot alias the framing word, so no match before six bytes.
  always_ff @(posedge clk19) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/rx_frame_align.sv
// STM-1 receive frame aligner: HUNT/PRESYNC/INFRAME acquisition with a
// flywheel frame counter, OOF/LOF status and per-frame error pulses.
module rx_frame_align
  import rx_frame_align_pkg::*;
#(
  parameter int unsigned FRMLEN  = FRMLEN_DEF,
  parameter logic [7:0]  A1PAT   = A1PAT_DEF,
  parameter logic [7:0]  A2PAT   = A2PAT_DEF,
  parameter int unsigned OOFERR  = OOFERR_DEF,
  parameter int unsigned LOFTIME = LOFTIME_DEF
) (
  input  logic       clk19,
  input  logic       rst,
  input  logic [7:0] dirx,
  output logic       rxsof,
  output logic       oof,
  output logic       lof,
  output logic       frmerr
);

  localparam logic [FCNT_W-1:0]   FCNT_LAST = FCNT_W'(FRMLEN - 1);
  localparam logic [ERRCNT_W-1:0] ERR_LIMIT = ERRCNT_W'(OOFERR);
  localparam logic [LOFTMR_W-1:0] LOF_LIMIT = LOFTMR_W'(LOFTIME);

  frm_state_e          state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
  logic [LOFTMR_W-1:0] loftmr_q, loftmr_d;
  logic                rxsof_q, rxsof_d;
  logic                frmerr_q, frmerr_d;
  logic                oof_q, oof_d;
  logic                lof_q, lof_d;

  logic                match_c;
  logic                check_pt_c;
  logic [FCNT_W-1:0]   fcnt_inc_c;
  logic [ERRCNT_W-1:0] errcnt_inc_c;

  rx_frame_align_a1a2_detect #(
    .A1PAT (A1PAT),
    .A2PAT (A2PAT)
  ) u_a1a2_detect (
    .clk19   (clk19),
    .rst     (rst),
    .dirx    (dirx),
    .match_c (match_c)
  );

  always_comb begin
    check_pt_c   = (fcnt_q == FCNT_LAST);
    fcnt_inc_c   = check_pt_c ? '0 : fcnt_q + FCNT_W'(1);
    errcnt_inc_c = errcnt_q + ERRCNT_W'(1);
  end

  // Acquisition / flywheel state machine.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_inc_c;
    errcnt_d = errcnt_q;
    rxsof_d  = 1'b0;
    frmerr_d = 1'b0;
    unique case (state_q)
      ST_HUNT: begin
        if (match_c) begin
          state_d = ST_PRESYNC;
          fcnt_d  = '0;
        end
      end
      ST_PRESYNC: begin
        if (check_pt_c) begin
          if (match_c) begin
            state_d = ST_INFRAME;
            rxsof_d = 1'b1;
          end else begin
            state_d = ST_HUNT;
          end
        end
      end
      ST_INFRAME: begin
        if (check_pt_c) begin
          if (match_c) begin
            errcnt_d = '0;
            rxsof_d  = 1'b1;
          end else begin
            frmerr_d = 1'b1;
            if (errcnt_inc_c == ERR_LIMIT) begin
              state_d  = ST_HUNT;
              errcnt_d = '0;
            end else begin
              errcnt_d = errcnt_inc_c;
              rxsof_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // LOF integrates the current OOF level; any OOF edge restarts the timer.
  always_comb begin
    oof_d = (state_d != ST_INFRAME);
    if (oof_d != oof_q) begin
      loftmr_d = '0;
    end else if (loftmr_q != LOF_LIMIT) begin
      loftmr_d = loftmr_q + LOFTMR_W'(1);
    end else begin
      loftmr_d = loftmr_q;
    end
    lof_d = (loftmr_d == LOF_LIMIT) ? oof_d : lof_q;
  end

  always_ff @(posedge clk19) begin
    if (rst) begin
      state_q  <= ST_HUNT;
      fcnt_q   <= '0;
      errcnt_q <= '0;
      loftmr_q <= '0;
      rxsof_q  <= 1'b0;
      frmerr_q <= 1'b0;
      oof_q    <= 1'b1;
      lof_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      errcnt_q <= errcnt_d;
      loftmr_q <= loftmr_d;
      rxsof_q  <= rxsof_d;
      frmerr_q <= frmerr_d;
      oof_q    <= oof_d;
      lof_q    <= lof_d;
    end
  end

  assign rxsof  = rxsof_q;
  assign frmerr = frmerr_q;
  assign oof    = oof_q;
  assign lof    = lof_q;

endmodule

// File: tb/tb_rx_frame_align.sv
// Self-checking bench for rx_frame_align: random filler bytes with framing
// words at controlled offsets, compared every cycle against a timeline model.
module tb_rx_frame_align;

  localparam int         FRMLEN  = 2430;
  localparam logic [7:0] A1      = 8'hF6;
  localparam logic [7:0] A2      = 8'h28;
  localparam int         OOFERR  = 4;
  localparam int         LOFTIME = 2 * FRMLEN;

  localparam int K_NONE = 0;
  localparam int K_GOOD = 1;
  localparam int K_BAD  = 2;

  localparam int M_HUNT = 0;
  localparam int M_PRE  = 1;
  localparam int M_IN   = 2;

  logic       clk19 = 1'b0;
  logic       rst;
  logic [7:0] dirx;
  logic       rxsof, oof, lof, frmerr;

  always #5 clk19 = ~clk19;

  rx_frame_align #(
    .FRMLEN  (FRMLEN),
    .A1PAT   (A1),
    .A2PAT   (A2),
    .OOFERR  (OOFERR),
    .LOFTIME (LOFTIME)
  ) dut (
    .clk19  (clk19),
    .rst    (rst),
    .dirx   (dirx),
    .rxsof  (rxsof),
    .oof    (oof),
    .lof    (lof),
    .frmerr (frmerr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: byte history, anchor cycle of the accepted framing word.
  logic [7:0] win[$];
  int  cyc = 0;
  int  anchor = 0;
  int  mode = M_HUNT;
  int  misses = 0;
  int  oof_age = 0;
  bit  e_rxsof = 1'b0, e_frmerr = 1'b0, e_oof = 1'b1, e_lof = 1'b0;
  int  n_rxsof = 0, n_frmerr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input logic [7:0] b, input logic r);
    bit hit, at_check, new_oof;
    if (r) begin
      win.delete();
      mode = M_HUNT; misses = 0; oof_age = 0;
      e_rxsof = 1'b0; e_frmerr = 1'b0; e_oof = 1'b1; e_lof = 1'b0;
      cyc++;
      return;
    end
    win.push_back(b);
    if (win.size() > 6) void'(win.pop_front());
    hit = (win.size() == 6) && win[0] == A1 && win[1] == A1 && win[2] == A1 &&
          win[3] == A2 && win[4] == A2 && win[5] == A2;
    at_check = (mode != M_HUNT) && (cyc > anchor) && (((cyc - anchor) % FRMLEN) == 0);
    e_rxsof = 1'b0;
    e_frmerr = 1'b0;
    if (mode == M_HUNT) begin
      if (hit) begin mode = M_PRE; anchor = cyc; end
    end else if (at_check) begin
      if (mode == M_PRE) begin
        if (hit) begin mode = M_IN; e_rxsof = 1'b1; end
        else mode = M_HUNT;
      end else if (hit) begin
        misses = 0; e_rxsof = 1'b1;
      end else begin
        misses++; e_frmerr = 1'b1;
        if (misses == OOFERR) begin mode = M_HUNT; misses = 0; end
        else e_rxsof = 1'b1;
      end
    end
    new_oof = (mode != M_IN);
    if (new_oof != e_oof) oof_age = 0;
    else if (oof_age < LOFTIME) oof_age++;
    e_oof = new_oof;
    if (oof_age == LOFTIME) e_lof = e_oof;
    cyc++;
  endfunction

  task automatic step(input logic [7:0] b, input logic r);
    dirx = b;
    rst  = r;
    @(posedge clk19);
    #1;
    model_step(b, r);
    check("outs", {28'd0, rxsof, oof, lof, frmerr}, {28'd0, e_rxsof, e_oof, e_lof, e_frmerr});
    if (rxsof === 1'b1) n_rxsof++;
    if (frmerr === 1'b1) n_frmerr++;
  endtask

  function automatic logic [7:0] filler();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == A1 || b == A2) b = 8'h55;
    return b;
  endfunction

  // n bytes ending with a framing word (good, corrupted) or with plain filler.
  task automatic emit_span(input int n, input int kind);
    logic [7:0] pat[6];
    int bad_idx;
    for (int i = 0; i < n - 6; i++) step(filler(), 1'b0);
    pat[0] = A1; pat[1] = A1; pat[2] = A1; pat[3] = A2; pat[4] = A2; pat[5] = A2;
    if (kind == K_BAD) begin
      bad_idx = int'($urandom_range(0, 5));
      pat[bad_idx] = filler();
    end
    for (int i = 0; i < 6; i++) step((kind == K_NONE) ? filler() : pat[i], 1'b0);
  endtask

  task automatic clear_counts();
    n_rxsof = 0;
    n_frmerr = 0;
  endtask

  initial begin
    rst  = 1'b1;
    dirx = 8'h00;
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    check("rst_oof", 32'(oof), 32'd1);
    check("rst_rxsof", 32'(rxsof), 32'd0);
    check("rst_lof", 32'(lof), 32'd0);
    check("rst_frmerr", 32'(frmerr), 32'd0);

    for (int i = 0; i < LOFTIME + 10; i++) step(filler(), 1'b0);
    check("lof_set", 32'(lof), 32'd1);

    // Acquisition from HUNT, then LOF clearing after a sustained in-frame period.
    clear_counts();
    emit_span(FRMLEN, K_GOOD);
    check("presync_oof", 32'(oof), 32'd1);
    check("presync_rxsof", 32'(rxsof), 32'd0);
    emit_span(FRMLEN, K_GOOD);
    check("acq_oof", 32'(oof), 32'd0);
    check("acq_rxsof", 32'(rxsof), 32'd1);
    step(filler(), 1'b0);
    check("sof_width", 32'(rxsof), 32'd0);
    emit_span(FRMLEN - 1, K_GOOD);
    check("lof_hold", 32'(lof), 32'd1);
    emit_span(FRMLEN, K_GOOD);
    check("lof_clear", 32'(lof), 32'd0);
    emit_span(FRMLEN, K_GOOD);
    check("phA_rxsof", 32'(n_rxsof), 32'd4);

    // Three errored frames are absorbed by the flywheel.
    clear_counts();
    for (int i = 0; i < 3; i++) emit_span(FRMLEN, K_BAD);
    emit_span(FRMLEN, K_GOOD);
    check("phB_frmerr", 32'(n_frmerr), 32'd3);
    check("phB_rxsof", 32'(n_rxsof), 32'd4);
    check("phB_oof", 32'(oof), 32'd0);

    // Four consecutive errored frames declare OOF.
    clear_counts();
    for (int i = 0; i < 3; i++) emit_span(FRMLEN, K_BAD);
    check("phC_oof3", 32'(oof), 32'd0);
    emit_span(FRMLEN, K_BAD);
    check("phC_oof4", 32'(oof), 32'd1);
    check("phC_frmerr", 32'(n_frmerr), 32'd4);
    check("phC_rxsof", 32'(n_rxsof), 32'd3);

    // PRESYNC ignores an off-position word and falls back on a bad check.
    clear_counts();
    emit_span(FRMLEN, K_GOOD);
    emit_span(1001, K_GOOD);
    emit_span(FRMLEN - 1001, K_BAD);
    check("phD_rxsof", 32'(n_rxsof), 32'd0);
    check("phD_oof", 32'(oof), 32'd1);

    // Mid-frame reset while in frame, then reacquisition.
    emit_span(FRMLEN, K_GOOD);
    emit_span(FRMLEN, K_GOOD);
    check("phE_inframe", 32'(oof), 32'd0);
    emit_span(1215, K_NONE);
    step(filler(), 1'b1);
    check("phE_rst_oof", 32'(oof), 32'd1);
    check("phE_rst_rxsof", 32'(rxsof), 32'd0);
    check("phE_rst_lof", 32'(lof), 32'd0);
    clear_counts();
    emit_span(FRMLEN, K_GOOD);
    check("phE_pre_oof", 32'(oof), 32'd1);
    emit_span(FRMLEN, K_GOOD);
    check("phE_reacq_oof", 32'(oof), 32'd0);
    check("phE_reacq_rxsof", 32'(n_rxsof), 32'd1);

    // Randomised spacing and corruption, checked by the model alone.
    for (int i = 0; i < 5; i++) begin
      int n;
      int kind;
      n = ($urandom_range(0, 3) == 0) ? FRMLEN + int'($urandom_range(0, 2)) - 1 : FRMLEN;
      kind = ($urandom_range(0, 2) == 0) ? K_BAD : K_GOOD;
      emit_span(n, kind);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_align.md
RX_FRAME_ALIGN -- requirements
Module: rx_frame_align

Interface
REQ-001 Parameter FRMLEN, default 2430, bytes per STM-1 frame (9 rows x 90 cols x 3 STS).
REQ-002 Parameter A1PAT, default 8'hF6, A1 framing byte.
REQ-003 Parameter A2PAT, default 8'h28, A2 framing byte.
REQ-004 Parameter OOFERR, default 4, consecutive errored frames that declare OOF.
REQ-005 Parameter LOFTIME, default 58320, cycles (24 frames) of persistent OOF or in-frame before LOF set or clear.
REQ-006 Port clk19, input, 1, byte clock; single clock domain.
REQ-007 Port rst, input, 1, reset; synchronous, active-high.
REQ-008 Port dirx, input, 8, byte-aligned receive data; one valid byte every clk19 cycle.
REQ-009 Port rxsof, output, 1, one-cycle start-of-frame pulse to the receive row/col/sts counter.
REQ-010 Port oof, output, 1, out-of-frame status.
REQ-011 Port lof, output, 1, loss-of-frame status.
REQ-012 Port frmerr, output, 1, one-cycle pulse per errored frame while in frame.

Function
REQ-013 Pattern match: the last five received bytes concatenated with the current dirx equal A1,A1,A1,A2,A2,A2; evaluated combinationally every cycle.
REQ-014 Frame position counter fcnt: 12 bits, range 0..FRMLEN-1, increments every cycle, wraps from FRMLEN-1 to 0. Check point: fcnt == FRMLEN-1.
REQ-015 States: HUNT, PRESYNC, INFRAME.
REQ-016 HUNT: on a match, go to PRESYNC and load fcnt = 0 on the next cycle; with no match, fcnt is don't-care.
REQ-017 PRESYNC: matches at non-check positions are ignored. At the check point, a match goes to INFRAME; a mismatch goes to HUNT.
REQ-018 INFRAME: matches at non-check positions are ignored; fcnt never reloads.
REQ-019 INFRAME check point with a match: clear the error count.
REQ-020 INFRAME check point with a mismatch: increment the 3-bit error count and pulse frmerr on the next cycle.
REQ-021 INFRAME: when the error count reaches OOFERR, go to HUNT and clear the error count.
REQ-022 rxsof is registered and asserts one cycle after a check point whose next state is INFRAME (the PRESYNC->INFRAME transition or INFRAME being held). An errored frame that does not reach OOFERR still pulses rxsof (flywheel).
REQ-023 oof is registered; oof = 1 whenever the state is not INFRAME.
REQ-024 LOF timer: 16 bits, clears on every oof transition, otherwise increments, saturating at LOFTIME.
REQ-025 lof sets when oof = 1 and the timer reaches LOFTIME; lof clears when oof = 0 and the timer reaches LOFTIME.
REQ-026 Latency: rxsof follows the last A2 byte on dirx by exactly 1 cycle; rxsof period in INFRAME is exactly FRMLEN cycles.

Reset
REQ-027 On rst, the following apply on the next edge: state HUNT; fcnt, error count, LOF timer and byte window all 0; rxsof 0, frmerr 0, oof 1, lof 0.
REQ-028 Because the byte window resets to 0, no false match is possible until six bytes have been received.
REQ-029 Asserting rst mid-frame in any state returns the block to HUNT within one cycle; there is no residual rxsof pulse.

Structure
REQ-030 FRMLEN, A1PAT, A2PAT, OOFERR, LOFTIME and the state encodings belong in the shared SDH framing package.
REQ-031 The 6-byte window and comparator form one sub-module, a1a2_detect (dirx in, match out); the state machine, counters and timers remain in rx_frame_align.

Verification
REQ-032 Frames with a correct A1/A2 every 2430 bytes after reset: oof falls after the 2nd pattern, first rxsof 1 cycle after that pattern's last A2 byte, then rxsof every 2430 cycles.
REQ-033 In INFRAME, corrupt A2 in 3 consecutive frames: 3 frmerr pulses, rxsof continues, oof stays 0. Corrupt a 4th consecutive frame: oof = 1 one cycle after that check point.
REQ-034 In PRESYNC, insert an extra pattern at fcnt 1000, then a bad pattern at the check point: return to HUNT with no rxsof issued.
REQ-035 Random data (pattern-free) for 58320 cycles after reset: lof = 1 at cycle 58320; then valid frames: lof = 0 58320 cycles after oof falls.
REQ-036 Assert rst for 1 cycle in INFRAME at fcnt 1215: oof = 1, rxsof = 0, lof unchanged-to-0, and reacquisition after two further patterns.
